// File: rtl/double_mat_conv_check.sv
// -----------------------------------------------------------------------------
// double_mat_conv_check
//
// Convergence checker for the unmixing-matrix update loop. It sits after the
// element-wise double subtractor and scans the difference matrix one element
// per clock in row-major order. It finds the largest |element| and where it
// is, then compares it against a tolerance. The result is reported with a
// one-cycle done pulse, and the iteration controller uses it to decide
// whether another update is needed.
//
// Sequence: IDLE -> SETTLE (wait for the subtractor pipeline) -> SCAN -> REPORT.
// Latency from an accepted start to done is 1 + SUB_LATENCY + SIZE_A*SIZE_B + 1.
//
// Optional feature (macro DOUBLE_MAT_CONV_NAN_CHECK_EN):
//   NaN elements are excluded from the max. Any NaN seen forces converged=0.
//   A sticky flag is reported on nan_flag.
//   Without the macro, NaNs take part in the raw bit compare.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle request to begin a check (ignored while busy)
//   mat_diff   difference matrix, element [r][c] at bits ((r*SIZE_B+c)*64) +: 64
//   tol        tolerance as IEEE-754 double, sampled on accepted start, sign ignored
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse when the result outputs are valid
//   converged  max_abs < tol (strict), held until the next done
//   max_abs    largest |element| as a double with sign bit 0
//   max_row    row index of max_abs
//   max_col    column index of max_abs
//   nan_flag   (only with DOUBLE_MAT_CONV_NAN_CHECK_EN) a NaN was scanned
// -----------------------------------------------------------------------------
module double_mat_conv_check #(
  parameter  int SIZE_A      = 8,
  parameter  int SIZE_B      = 8,
  parameter  int SUB_LATENCY = 5,
  localparam int RW          = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
  localparam int CW          = (SIZE_B > 1) ? $clog2(SIZE_B) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SIZE_A*SIZE_B*64-1:0] mat_diff,
  input  logic [63:0]                tol,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [63:0]                max_abs,
  output logic [RW-1:0]              max_row,
  output logic [CW-1:0]              max_col
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
  ,
  output logic                       nan_flag
`endif
);

  localparam int CNTW = (SUB_LATENCY > 0) ? $clog2(SUB_LATENCY + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

  // Clearing bit 63 gives the absolute value. Keeping all values 64 bits
  // wide with bit 63 at zero makes a 64-bit unsigned compare equal to the
  // 63-bit magnitude compare.
  localparam logic [63:0] ABS_MASK = 64'h7FFF_FFFF_FFFF_FFFF;

  // Unpack the flat matrix port into an indexable array.
  logic [63:0] elems [SIZE_A][SIZE_B];

  for (genvar r = 0; r < SIZE_A; r++) begin : g_row
    for (genvar c = 0; c < SIZE_B; c++) begin : g_col
      assign elems[r][c] = mat_diff[(r*SIZE_B + c)*64 +: 64];
    end
  end

  // State, counters and running maximum.
  logic [1:0]      state_q,   state_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  logic [RW-1:0]   row_q,     row_d;
  logic [CW-1:0]   col_q,     col_d;
  logic [63:0]     tol_q,     tol_d;
  logic [63:0]     run_max_q, run_max_d;
  logic [RW-1:0]   run_row_q, run_row_d;
  logic [CW-1:0]   run_col_q, run_col_d;

  // Registered outputs.
  logic            done_q,      done_d;
  logic            converged_q, converged_d;
  logic [63:0]     max_abs_q,   max_abs_d;
  logic [RW-1:0]   max_row_q,   max_row_d;
  logic [CW-1:0]   max_col_q,   max_col_d;

`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
  logic            nan_seen_q, nan_seen_d;
  logic            nan_flag_q, nan_flag_d;
  logic            nan_any;
`endif

  // Current element and the candidate max after including it.
  logic [63:0]     elem_abs;
  logic            elem_nan;
  logic            elem_take;
  logic [63:0]     cand_max;
  logic [RW-1:0]   cand_row;
  logic [CW-1:0]   cand_col;
  logic            last_elem;

  always_comb begin
    elem_abs  = elems[row_q][col_q] & ABS_MASK;
    elem_nan  = (&elem_abs[62:52]) && (|elem_abs[51:0]);
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
    elem_take = !elem_nan && (elem_abs > run_max_q);
`else
    // A NaN is not filtered here. It competes as a raw bit pattern.
    elem_take = (elem_abs > run_max_q) || (elem_nan && 1'b0);
`endif
    // Strictly greater replaces the max, so ties keep the earliest index.
    cand_max  = elem_take ? elem_abs : run_max_q;
    cand_row  = elem_take ? row_q    : run_row_q;
    cand_col  = elem_take ? col_q    : run_col_q;
    last_elem = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. Any
    // path that misses an assignment would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    tol_d       = tol_q;
    run_max_d   = run_max_q;
    run_row_d   = run_row_q;
    run_col_d   = run_col_q;
    done_d      = 1'b0;
    converged_d = converged_q;
    max_abs_d   = max_abs_q;
    max_row_d   = max_row_q;
    max_col_d   = max_col_q;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
    nan_seen_d  = nan_seen_q;
    nan_flag_d  = nan_flag_q;
    nan_any     = nan_seen_q || elem_nan;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tol_d     = tol & ABS_MASK;
          run_max_d = '0;
          run_row_d = '0;
          run_col_d = '0;
          row_d     = '0;
          col_d     = '0;
          cnt_d     = CNTW'(SUB_LATENCY);
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
          nan_seen_d = 1'b0;
`endif
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // The count runs down to zero and includes zero, so SETTLE lasts
        // SUB_LATENCY+1 cycles. The first scanned element is then stable.
        if (cnt_q == '0) begin
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      ST_SCAN: begin
        run_max_d = cand_max;
        run_row_d = cand_row;
        run_col_d = cand_col;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
        nan_seen_d = nan_any;
`endif
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end

        if (last_elem) begin
          // Load the results on the same edge that enters REPORT, so that
          // they are valid while done is high.
          row_d       = '0;
          col_d       = '0;
          state_d     = ST_REPORT;
          done_d      = 1'b1;
          max_abs_d   = cand_max;
          max_row_d   = cand_row;
          max_col_d   = cand_col;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
          converged_d = (cand_max < tol_q) && !nan_any;
          nan_flag_d  = nan_any;
`else
          converged_d = (cand_max < tol_q);
`endif
        end
      end

      ST_REPORT: begin
        // A start request in this cycle is deliberately not accepted.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values taken before the edge.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      tol_q       <= '0;
      run_max_q   <= '0;
      run_row_q   <= '0;
      run_col_q   <= '0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      max_abs_q   <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
      nan_seen_q  <= 1'b0;
      nan_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tol_q       <= tol_d;
      run_max_q   <= run_max_d;
      run_row_q   <= run_row_d;
      run_col_q   <= run_col_d;
      done_q      <= done_d;
      converged_q <= converged_d;
      max_abs_q   <= max_abs_d;
      max_row_q   <= max_row_d;
      max_col_q   <= max_col_d;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
      nan_seen_q  <= nan_seen_d;
      nan_flag_q  <= nan_flag_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign converged = converged_q;
  assign max_abs   = max_abs_q;
  assign max_row   = max_row_q;
  assign max_col   = max_col_q;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
  assign nan_flag  = nan_flag_q;
`endif

endmodule

// File: tb/tb_double_mat_conv_check.sv
module tb_double_mat_conv_check;

  localparam int SA  = 8;
  localparam int SB  = 8;
  localparam int LAT = 71;

  localparam logic [63:0] D_ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] D_NZERO = 64'h8000_0000_0000_0000;
  localparam logic [63:0] D_1EM6  = 64'h3EB0_C6F7_A0B5_ED8D;
  localparam logic [63:0] D_1EM9  = 64'h3E11_2E0B_E826_D695;
  localparam logic [63:0] D_M2P5  = 64'hC004_0000_0000_0000;
  localparam logic [63:0] D_2P5   = 64'h4004_0000_0000_0000;
  localparam logic [63:0] D_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_MONE  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] D_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D_INF   = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] D_MINF  = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] D_QNAN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] D_SMALL = 64'hBF50_624D_D2F1_A9FC;
  localparam logic [63:0] D_SMABS = 64'h3F50_624D_D2F1_A9FC;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [SA*SB*64-1:0]   mat_diff;
  logic [63:0]           tol;
  logic                  busy;
  logic                  done;
  logic                  converged;
  logic [63:0]           max_abs;
  logic [2:0]            max_row;
  logic [2:0]            max_col;
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
  logic                  nan_flag;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  double_mat_conv_check dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_diff  (mat_diff),
    .tol       (tol),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .max_abs   (max_abs),
    .max_row   (max_row),
    .max_col   (max_col)
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
    ,
    .nan_flag  (nan_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] fill;
    int          r0, c0;
    logic [63:0] v0;
    int          r1, c1;
    logic [63:0] v1;
    logic [63:0] tol;
    logic [63:0] e_max;
    int          e_row, e_col;
    logic        e_conv;
    logic        e_nan;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_mat(input logic [63:0] fill, input int r0, input int c0, input logic [63:0] v0,
                         input int r1, input int c1, input logic [63:0] v1);
    for (int i = 0; i < SA*SB; i++) mat_diff[i*64 +: 64] = fill;
    if (r0 >= 0) mat_diff[(r0*SB + c0)*64 +: 64] = v0;
    if (r1 >= 0) mat_diff[(r1*SB + c1)*64 +: 64] = v1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start from an idle cycle and wait for done. Returns in the done
  // cycle, with lat = edges counted from the accepting edge (which is 1).
  task automatic run_check(input string name, output int lat);
    start = 1'b1;
    lat   = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        check({name, " busy after start"}, 64'(busy), 64'd1);
      end
      if (done) break;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
  endtask

  task automatic check_result(input string name, input logic [63:0] e_max, input int e_row,
                              input int e_col, input logic e_conv);
    check({name, " max_abs"},   max_abs,          e_max);
    check({name, " max_row"},   64'(max_row),     64'(e_row));
    check({name, " max_col"},   64'(max_col),     64'(e_col));
    check({name, " converged"}, 64'(converged),   64'(e_conv));
  endtask

  initial begin
    int lat;
    int n_done;
    int first_done;
    bit hold_ok;

    // name, fill, r0,c0,v0, r1,c1,v1, tol, e_max, e_row,e_col, e_conv, e_nan
    vecs[0] = '{"zeros",     D_ZERO,  -1,0,D_ZERO,  -1,0,D_ZERO, D_1EM6, D_ZERO,  0,0, 1'b1, 1'b0};
    vecs[1] = '{"neg2p5",    D_1EM9,   3,5,D_M2P5,  -1,0,D_ZERO, D_1EM6, D_2P5,   3,5, 1'b0, 1'b0};
    vecs[2] = '{"tie_eq",    D_ZERO,   1,1,D_1EM6,   6,2,D_1EM6, D_1EM6, D_1EM6,  1,1, 1'b0, 1'b0};
    vecs[3] = '{"last_el",   D_ZERO,   0,0,D_NZERO,  7,7,D_ONE,  D_INF,  D_ONE,   7,7, 1'b1, 1'b0};
    vecs[4] = '{"tol_zero",  D_ZERO,  -1,0,D_ZERO,  -1,0,D_ZERO, D_ZERO, D_ZERO,  0,0, 1'b0, 1'b0};
    vecs[5] = '{"inf_el",    D_ZERO,   4,0,D_MINF,  -1,0,D_ZERO, D_INF,  D_INF,   4,0, 1'b0, 1'b0};
    vecs[6] = '{"neg_tol",   D_SMALL, -1,0,D_ZERO,  -1,0,D_ZERO, D_MONE, D_SMABS, 0,0, 1'b1, 1'b0};
    vecs[7] = '{"row_order", D_ZERO,   0,7,D_TWO,    7,0,D_THREE,D_ONE,  D_THREE, 7,0, 1'b0, 1'b0};
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
    vecs[8] = '{"nan",       D_ZERO,   0,7,D_QNAN,  -1,0,D_ZERO, D_ONE,  D_ZERO,  0,0, 1'b0, 1'b1};
`else
    vecs[8] = '{"nan",       D_ZERO,   0,7,D_QNAN,  -1,0,D_ZERO, D_ONE,  D_QNAN,  0,7, 1'b0, 1'b0};
`endif

    rst   = 1'b1;
    start = 1'b0;
    tol   = '0;
    set_mat(D_ONE, -1, 0, D_ZERO, -1, 0, D_ZERO);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset busy",      64'(busy),      64'd0);
    check("reset done",      64'(done),      64'd0);
    check_result("reset", D_ZERO, 0, 0, 1'b0);

    // Table-driven checks
    foreach (vecs[i]) begin
      set_mat(vecs[i].fill, vecs[i].r0, vecs[i].c0, vecs[i].v0, vecs[i].r1, vecs[i].c1, vecs[i].v1);
      tol = vecs[i].tol;
      run_check(vecs[i].name, lat);
      check_result(vecs[i].name, vecs[i].e_max, vecs[i].e_row, vecs[i].e_col, vecs[i].e_conv);
`ifdef DOUBLE_MAT_CONV_NAN_CHECK_EN
      check({vecs[i].name, " nan_flag"}, 64'(nan_flag), 64'(vecs[i].e_nan));
`endif
      tick();
      check({vecs[i].name, " done width"}, 64'(done), 64'd0);
      check({vecs[i].name, " busy fall"},  64'(busy), 64'd0);
    end

    // A start pulsed 10 cycles into SCAN is ignored and not queued
    set_mat(D_1EM9, 3, 5, D_M2P5, -1, 0, D_ZERO);
    tol        = D_1EM6;
    start      = 1'b1;
    n_done     = 0;
    first_done = 0;
    for (int c = 1; c <= 160; c++) begin
      tick();
      if (c == 1)  start = 1'b0;
      if (c == 17) start = 1'b1;
      if (c == 18) start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
    end
    check("ignore start done count", 64'(n_done),     64'd1);
    check("ignore start latency",    64'(first_done), 64'(LAT));
    check_result("ignore start", D_2P5, 3, 5, 1'b0);

    // Reset in cycle 30 of a scan aborts it without a done
    tol   = D_1EM6;
    start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (done) n_done++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check_result("abort", D_ZERO, 0, 0, 1'b0);
    for (int c = 0; c < 90; c++) begin
      tick();
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);

    // Back-to-back: start during done is ignored, start in the next cycle is accepted
    set_mat(D_1EM9, 3, 5, D_M2P5, -1, 0, D_ZERO);
    tol = D_1EM6;
    run_check("b2b first", lat);
    check_result("b2b first", D_2P5, 3, 5, 1'b0);
    set_mat(D_ZERO, -1, 0, D_ZERO, -1, 0, D_ZERO);
    start = 1'b1;
    tick();
    check("start in done ignored", 64'(busy), 64'd0);
    tick();
    start   = 1'b0;
    lat     = 1;
    hold_ok = 1'b1;
    while (!done && lat < 200) begin
      if (max_abs !== D_2P5 || max_row !== 3'd3 || max_col !== 3'd5 || converged !== 1'b0)
        hold_ok = 1'b0;
      tick();
      lat++;
    end
    check("b2b outputs held", 64'(hold_ok), 64'd1);
    check("b2b second latency", 64'(lat), 64'(LAT));
    check_result("b2b second", D_ZERO, 0, 0, 1'b1);
    tick();
    check("b2b done width", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/double_mat_conv_check.md
Name: double_mat_conv_check

Overview:
- Downstream of the element-wise double matrix subtractor.
- Consumes the difference matrix (W_new − W_old) from the unmixing-matrix update loop.
- Scans the matrix sequentially, finds the largest absolute element and its position, and compares it against a tolerance to flag convergence.
- A start/done handshake lets the iteration controller decide whether to stop or run another update.

Parameters:
- SIZE_A, 8, number of rows in the difference matrix.
- SIZE_B, 8, number of columns in the difference matrix.
- SUB_LATENCY, 5, pipeline depth in cycles of the upstream subtractor. mat_diff is valid SUB_LATENCY cycles after its inputs change.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a check. Ignored while busy=1.
- mat_diff  in  double[SIZE_A][SIZE_B]  difference matrix from the subtractor
- tol  in  64  tolerance as an IEEE-754 double. Sampled on an accepted start; sign bit ignored.
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the result is valid
- converged  out  1  1 if max_abs < tol (strict). Held until the next done.
- max_abs  out  64  largest |element|, as a double with sign bit 0
- max_row  out  $clog2(SIZE_A) (min 1)  row index of max_abs
- max_col  out  $clog2(SIZE_B) (min 1)  column index of max_abs

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; counters 0. Reset takes priority in every state and aborts any scan without raising done.
- States:
  - IDLE: on start=1, latch tol with its sign cleared; clear running max to +0.0 at index (0,0); load wait counter with SUB_LATENCY; go to SETTLE.
  - SETTLE: decrement the counter each cycle; go to SCAN when it reaches 0. SUB_LATENCY=0 passes straight through to SCAN after one cycle.
  - SCAN: read one element per cycle in row-major order (row 0 col 0 … row SIZE_A−1 col SIZE_B−1).
    - Absolute value = element with bit 63 cleared.
    - Magnitude compare = unsigned 63-bit compare of bits [62:0]. This is valid for non-NaN values, including ±0 and infinity.
    - Strictly greater replaces the running max and index, so ties keep the earliest index.
    - On the last element go to REPORT.
  - REPORT: register the outputs, assert done for exactly one cycle, return to IDLE.
- Latency from start to done = 1 + SUB_LATENCY + SIZE_A·SIZE_B + 1 cycles. Defaults: 71.
- busy=1 in SETTLE, SCAN and REPORT; it falls in the cycle after done.
- start while busy is ignored and not queued.
- start in the same cycle as done (the REPORT state) is ignored.
- Changes to mat_diff during SCAN are not protected against. The controller must hold the subtractor inputs stable from start until done.
- Outputs are updated only at REPORT and keep their values until the next REPORT or reset.
- Column counter wraps to 0 and the row counter increments when col = SIZE_B−1.
- converged compare: tol = +0.0 gives converged=0 always. tol = +inf gives converged=1 unless max_abs is inf.

Optional Feature:
- Macro: DOUBLE_MAT_CONV_NAN_CHECK_EN.
- Defined:
  - Each scanned element with exponent 0x7FF and mantissa ≠ 0 sets a sticky nan_seen flag, cleared at start.
  - NaN elements are excluded from the max.
  - At REPORT, converged is forced to 0 when nan_seen=1.
  - An extra output port nan_flag (1 bit, reset 0) presents nan_seen and is updated at REPORT.
- Undefined:
  - No nan_flag port.
  - NaNs take part in the raw bit compare; a NaN with the larger bit pattern wins. Result is unspecified numerically.

Test Plan:
- All-zero matrix, tol=1e-6 (0x3EB0C6F7A0B5ED8D), start → done at cycle 71; max_abs=0x0000000000000000; row=0, col=0; converged=1.
- Element [3][5] = −2.5 (0xC004000000000000), the rest 1.0e-9, tol=1e-6 → max_abs=0x4004000000000000; row=3, col=5; converged=0.
- Elements [1][1] and [6][2] both = 1e-6, all others 0, tol=1e-6 → max at (1,1) (earliest wins); converged=0 (strict less-than).
- start pulsed again 10 cycles into SCAN → ignored; a single done at cycle 71. Then rst asserted at cycle 30 of a second scan → done never rises; all outputs 0 in the cycle after rst.
- Back-to-back checks: start in the cycle after done → accepted; second done exactly 71 cycles later; outputs between the two done pulses equal the first result.
- With DOUBLE_MAT_CONV_NAN_CHECK_EN: [0][7] = 0x7FF8000000000000, the rest 0, tol=1.0 → nan_flag=1, converged=0, max_abs=0.
